// File: rtl/req_enc_pkg.sv
// Shared types and constants for the request priority encoder.
package req_enc_pkg;

  localparam int NREQ   = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } enc_state_t;

  localparam logic [CODE_W-1:0] BILL = 3'd0;
  localparam logic [CODE_W-1:0] MARY = 3'd1;
  localparam logic [CODE_W-1:0] JOAN = 3'd2;
  localparam logic [CODE_W-1:0] PAUL = 3'd3;
  localparam logic [CODE_W-1:0] ANNA = 3'd4;
  localparam logic [CODE_W-1:0] FRED = 3'd5;
  localparam logic [CODE_W-1:0] DAVE = 3'd6;
  localparam logic [CODE_W-1:0] KATE = 3'd7;

endpackage

// File: rtl/req_priority_encoder_if.sv
// Station request / group-select bus between the encoder (master) and the name decoder (slave).
interface req_priority_encoder_if;

  logic [req_enc_pkg::NREQ-1:0] REQ_L;
  logic                         ACK;
  logic                         GS_L;
  logic                         A2;
  logic                         A1;
  logic                         A0;
  logic                         BUSY;
  logic                         TMO;

  modport master (
    input  REQ_L, ACK,
    output GS_L, A2, A1, A0, BUSY, TMO
  );

  modport slave (
    output REQ_L, ACK,
    input  GS_L, A2, A1, A0, BUSY, TMO
  );

endinterface

// File: rtl/prio8_enc.sv
// Combinational 8->3 encoder: highest set index wins; vld flags any bit set.
module prio8_enc
  import req_enc_pkg::*;
(
  input  logic [NREQ-1:0]   req,
  output logic [CODE_W-1:0] idx,
  output logic              vld
);

  always_comb begin
    idx = '0;
    vld = 1'b0;
    // Ascending scan so the last (highest) set bit overrides lower ones.
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        idx = CODE_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_priority_encoder.sv
// Captures REQ_L falling edges as pending bits and presents the highest one on GS_L/A2..A0 (2 clk from idle),
// holding it until ACK. Optional ACK watchdog with TMO pulse under REQ_ENC_ACK_TIMEOUT_EN.
module req_priority_encoder
  import req_enc_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input logic                    CLK,
  input logic                    RESET,
  req_priority_encoder_if.master bus
);

  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_timeout
    $error("ACK_TIMEOUT must be in 1..255");
  end

  enc_state_t        state;
  logic [NREQ-1:0]   req_hist;
  logic [NREQ-1:0]   pending;
  logic [NREQ-1:0]   events;
  logic [NREQ-1:0]   clr;
  logic [NREQ-1:0]   pending_nxt;
  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] win_idx;
  logic              win_vld;
  logic              gs_l;
  logic              busy;
  logic              ack_take;
  logic              tmo_fire;
  logic              drop;
  logic              present_nxt;

  prio8_enc u_arb (
    .req (pending),
    .idx (win_idx),
    .vld (win_vld)
  );

`ifdef REQ_ENC_ACK_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       tmo_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= tmo_fire;
      if (state == IDLE) tmo_cnt <= '0;
      else if (!drop)    tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  assign tmo_fire = (state == PRESENT) && !bus.ACK && (tmo_cnt == 8'(ACK_TIMEOUT));
  assign bus.TMO  = tmo_q;
`else
  assign tmo_fire = 1'b0;
  assign bus.TMO  = 1'b0;
`endif

  always_comb begin
    events   = req_hist & ~bus.REQ_L;
    ack_take = (state == PRESENT) && bus.ACK;
    drop     = ack_take || tmo_fire;
    clr      = drop ? (NREQ'(1) << code) : '0;
    // A fresh event on the serviced line outranks the clear so it is not lost.
    pending_nxt = (pending & ~clr) | events;
    present_nxt = (state == IDLE) ? win_vld : !drop;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      req_hist <= '1;
      pending  <= '0;
      code     <= '0;
      gs_l     <= 1'b1;
      busy     <= 1'b0;
    end else begin
      req_hist <= bus.REQ_L;
      pending  <= pending_nxt;
      busy     <= (pending_nxt != '0) || present_nxt;
      if (state == IDLE) begin
        if (win_vld) begin
          code  <= win_idx;
          gs_l  <= 1'b0;
          state <= PRESENT;
        end
      end else if (drop) begin
        gs_l  <= 1'b1;
        state <= IDLE;
      end
    end
  end

  assign bus.GS_L = gs_l;
  assign bus.A2   = code[2];
  assign bus.A1   = code[1];
  assign bus.A0   = code[0];
  assign bus.BUSY = busy;

endmodule

// File: tb/tb_req_priority_encoder.sv
// Directed-vector bench for req_priority_encoder; timeout steps build only with REQ_ENC_ACK_TIMEOUT_EN.
module tb_req_priority_encoder;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  req_priority_encoder_if bus ();

  req_priority_encoder #(.ACK_TIMEOUT(15)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] code_now();
    return {5'b0, bus.A2, bus.A1, bus.A0};
  endfunction

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    bus.REQ_L = 8'hFF;
    bus.ACK   = 1'b0;
    #1;
    chk("rst_gs", {7'b0, bus.GS_L}, 8'd1);
    chk("rst_code", code_now(), 8'd0);
    chk("rst_busy", {7'b0, bus.BUSY}, 8'd0);
    chk("rst_tmo", {7'b0, bus.TMO}, 8'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single request on JOAN: 2-clock latency, then ACK clears it.
    bus.REQ_L = 8'hFB;
    tick();
    chk("joan_cap_gs", {7'b0, bus.GS_L}, 8'd1);
    chk("joan_cap_busy", {7'b0, bus.BUSY}, 8'd1);
    bus.REQ_L = 8'hFF;
    tick();
    chk("joan_gs", {7'b0, bus.GS_L}, 8'd0);
    chk("joan_code", code_now(), 8'd2);
    bus.ACK = 1'b1;
    tick();
    chk("joan_ack_gs", {7'b0, bus.GS_L}, 8'd1);
    chk("joan_ack_busy", {7'b0, bus.BUSY}, 8'd0);
    bus.ACK = 1'b0;
    tick();

    // MARY, FRED, DAVE together: served 6, 5, 1; ACK held through IDLE is ignored.
    bus.REQ_L = 8'h9D;
    tick();
    bus.REQ_L = 8'hFF;
    tick();
    chk("multi_code6", code_now(), 8'd6);
    chk("multi_gs6", {7'b0, bus.GS_L}, 8'd0);
    bus.ACK = 1'b1;
    tick();
    chk("multi_gap1", {7'b0, bus.GS_L}, 8'd1);
    chk("multi_busy1", {7'b0, bus.BUSY}, 8'd1);
    tick();
    chk("multi_gs5", {7'b0, bus.GS_L}, 8'd0);
    chk("multi_code5", code_now(), 8'd5);
    tick();
    chk("multi_gap2", {7'b0, bus.GS_L}, 8'd1);
    bus.ACK = 1'b0;
    tick();
    chk("multi_code1", code_now(), 8'd1);
    chk("multi_gs1", {7'b0, bus.GS_L}, 8'd0);
    tick();
    chk("multi_hold1", code_now(), 8'd1);
    bus.ACK = 1'b1;
    tick();
    chk("multi_done_gs", {7'b0, bus.GS_L}, 8'd1);
    chk("multi_done_busy", {7'b0, bus.BUSY}, 8'd0);
    bus.ACK = 1'b0;
    tick();

    // KATE arrives while PAUL is presented: no preemption.
    bus.REQ_L = 8'hF7;
    tick();
    bus.REQ_L = 8'hFF;
    tick();
    chk("paul_code", code_now(), 8'd3);
    bus.REQ_L = 8'h7F;
    tick();
    chk("paul_hold_code", code_now(), 8'd3);
    chk("paul_hold_gs", {7'b0, bus.GS_L}, 8'd0);
    bus.REQ_L = 8'hFF;
    tick();
    chk("paul_hold2", code_now(), 8'd3);
    bus.ACK = 1'b1;
    tick();
    chk("paul_ack_gs", {7'b0, bus.GS_L}, 8'd1);
    bus.ACK = 1'b0;
    tick();
    chk("kate_code", code_now(), 8'd7);
    chk("kate_gs", {7'b0, bus.GS_L}, 8'd0);
    bus.ACK = 1'b1;
    tick();
    chk("kate_ack_busy", {7'b0, bus.BUSY}, 8'd0);
    bus.ACK = 1'b0;

    // ANNA held low: one service only until released and re-asserted.
    bus.REQ_L = 8'hEF;
    tick();
    tick();
    chk("anna_code", code_now(), 8'd4);
    bus.ACK = 1'b1;
    tick();
    bus.ACK = 1'b0;
    tick();
    tick();
    chk("anna_held_gs", {7'b0, bus.GS_L}, 8'd1);
    chk("anna_held_busy", {7'b0, bus.BUSY}, 8'd0);
    bus.REQ_L = 8'hFF;
    tick();
    bus.REQ_L = 8'hEF;
    tick();
    tick();
    chk("anna_again_gs", {7'b0, bus.GS_L}, 8'd0);
    chk("anna_again_code", code_now(), 8'd4);
    bus.ACK = 1'b1;
    tick();
    bus.ACK   = 1'b0;
    bus.REQ_L = 8'hFF;
    tick();

    // BILL: new event coincides with its own ACK and must survive.
    bus.REQ_L = 8'hFE;
    tick();
    bus.REQ_L = 8'hFF;
    tick();
    chk("bill_code", code_now(), 8'd0);
    chk("bill_gs", {7'b0, bus.GS_L}, 8'd0);
    bus.ACK   = 1'b1;
    bus.REQ_L = 8'hFE;
    tick();
    chk("bill_race_gs", {7'b0, bus.GS_L}, 8'd1);
    chk("bill_race_busy", {7'b0, bus.BUSY}, 8'd1);
    bus.ACK   = 1'b0;
    bus.REQ_L = 8'hFF;
    tick();
    chk("bill_again_gs", {7'b0, bus.GS_L}, 8'd0);
    chk("bill_again_code", code_now(), 8'd0);
    bus.ACK = 1'b1;
    tick();
    chk("bill_done_busy", {7'b0, bus.BUSY}, 8'd0);
    bus.ACK = 1'b0;
    tick();

`ifdef REQ_ENC_ACK_TIMEOUT_EN
    // FRED presented with ACK withheld: dropped on the 16th PRESENT edge.
    bus.REQ_L = 8'hDF;
    tick();
    bus.REQ_L = 8'hFF;
    tick();
    chk("tmo_code", code_now(), 8'd5);
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("tmo_wait_gs", {7'b0, bus.GS_L}, 8'd0);
      chk("tmo_wait_tmo", {7'b0, bus.TMO}, 8'd0);
    end
    tick();
    chk("tmo_fire_tmo", {7'b0, bus.TMO}, 8'd1);
    chk("tmo_fire_gs", {7'b0, bus.GS_L}, 8'd1);
    chk("tmo_fire_busy", {7'b0, bus.BUSY}, 8'd0);
    tick();
    chk("tmo_pulse_end", {7'b0, bus.TMO}, 8'd0);
    chk("tmo_no_repend", {7'b0, bus.GS_L}, 8'd1);
`endif

    // Reset asserted mid-PRESENT takes effect without a clock edge.
    bus.REQ_L = 8'hBF;
    tick();
    bus.REQ_L = 8'hFF;
    tick();
    chk("mid_code", code_now(), 8'd6);
    bus.REQ_L = 8'hFD;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_gs", {7'b0, bus.GS_L}, 8'd1);
    chk("mid_rst_code", code_now(), 8'd0);
    chk("mid_rst_busy", {7'b0, bus.BUSY}, 8'd0);
    chk("mid_rst_tmo", {7'b0, bus.TMO}, 8'd0);
    bus.REQ_L = 8'hFF;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_gs", {7'b0, bus.GS_L}, 8'd1);
    chk("post_rst_busy", {7'b0, bus.BUSY}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
